// File: rtl/vc_clkdivratioloader.sv
// Programmable integer clock divider; the divide ratio arrives over valid/ready and is applied on a period boundary.
// Optional status outputs (ratio_active, update_done) are enabled by defining CLKDIV_STATUS_EN.
module vc_clkdivratioloader #(
  parameter int p_nbits       = 8,
  parameter int p_reset_ratio = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ratio_val,
  output logic               ratio_rdy,
  input  logic [p_nbits-1:0] ratio,
  input  logic               run,
  output logic               clk_en,
  output logic               clk_div
`ifdef CLKDIV_STATUS_EN
  ,
  output logic [p_nbits-1:0] ratio_active,
  output logic               update_done
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PENDING = 2'd2
  } state_t;

  state_t             r_state;
  logic [p_nbits-1:0] r_cnt;
  logic [p_nbits-1:0] r_active;
  logic [p_nbits-1:0] r_shadow;
  logic               r_clk_en;
  logic               r_clk_div;

  logic               w_xfer;
  logic [p_nbits-1:0] w_ratio_clamp;
  logic               w_wrap;
  logic [p_nbits-1:0] w_cnt_inc;
  logic [p_nbits-1:0] w_half;
  logic               w_div_inc;

  assign ratio_rdy     = (r_state != S_PENDING);
  assign w_xfer        = ratio_val && ratio_rdy;
  assign w_ratio_clamp = (ratio < p_nbits'(2)) ? p_nbits'(2) : ratio;

  // Compare against active-1 so the maximum ratio never needs an extra counter bit.
  assign w_wrap    = (r_cnt == (r_active - p_nbits'(1)));
  assign w_cnt_inc = w_wrap ? '0 : (r_cnt + p_nbits'(1));
  assign w_half    = (r_active >> 1) + {{(p_nbits-1){1'b0}}, r_active[0]};
  // On a wrap the next count is 0, which is high for any ratio >= 2, so the old ratio suffices here.
  assign w_div_inc = (w_cnt_inc < w_half);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_active  <= p_nbits'(p_reset_ratio);
      r_shadow  <= '0;
      r_clk_en  <= 1'b0;
      r_clk_div <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt     <= '0;
          r_clk_en  <= 1'b0;
          r_clk_div <= 1'b0;
          if (w_xfer) begin
            r_active <= w_ratio_clamp;
          end
          if (run) begin
            r_state   <= S_RUN;
            r_clk_en  <= 1'b1;
            r_clk_div <= 1'b1;
          end
        end
        S_RUN: begin
          if (!run) begin
            // Stopping with a ratio offered: no period left to protect, so apply it now.
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_clk_en  <= 1'b0;
            r_clk_div <= 1'b0;
            if (w_xfer) begin
              r_active <= w_ratio_clamp;
            end
          end else begin
            r_cnt     <= w_cnt_inc;
            r_clk_en  <= w_wrap;
            r_clk_div <= w_div_inc;
            if (w_xfer) begin
              r_shadow <= w_ratio_clamp;
              r_state  <= S_PENDING;
            end
          end
        end
        S_PENDING: begin
          if (!run || w_wrap) begin
            r_active <= r_shadow;
          end
          if (!run) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_clk_en  <= 1'b0;
            r_clk_div <= 1'b0;
          end else begin
            r_cnt     <= w_cnt_inc;
            r_clk_en  <= w_wrap;
            r_clk_div <= w_div_inc;
            if (w_wrap) begin
              r_state <= S_RUN;
            end
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_cnt     <= '0;
          r_clk_en  <= 1'b0;
          r_clk_div <= 1'b0;
        end
      endcase
    end
  end

  assign clk_en  = r_clk_en;
  assign clk_div = r_clk_div;

`ifdef CLKDIV_STATUS_EN
  logic w_load;
  logic r_update_done;

  // Every edge on which the FSM above writes r_active.
  assign w_load = ((r_state == S_IDLE) && w_xfer) ||
                  ((r_state == S_RUN) && !run && w_xfer) ||
                  ((r_state == S_PENDING) && (!run || w_wrap));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_update_done <= 1'b0;
    end else begin
      r_update_done <= w_load;
    end
  end

  assign ratio_active = r_active;
  assign update_done  = r_update_done;
`endif

endmodule

// File: tb/tb_vc_clkdivratioloader.sv
// Directed bench for vc_clkdivratioloader: hand-derived clk_en/clk_div waveforms per divide ratio.
// Status ports are connected and checked when CLKDIV_STATUS_EN is defined.
module tb_vc_clkdivratioloader;

  logic       clk = 1'b0;
  logic       reset;
  logic       ratio_val;
  logic       ratio_rdy;
  logic [7:0] ratio;
  logic       run;
  logic       clk_en;
  logic       clk_div;
`ifdef CLKDIV_STATUS_EN
  logic [7:0] ratio_active;
  logic       update_done;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vc_clkdivratioloader #(.p_nbits(8), .p_reset_ratio(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .ratio_val (ratio_val),
    .ratio_rdy (ratio_rdy),
    .ratio     (ratio),
    .run       (run),
    .clk_en    (clk_en),
    .clk_div   (clk_div)
`ifdef CLKDIV_STATUS_EN
    ,
    .ratio_active (ratio_active),
    .update_done  (update_done)
`endif
  );

  // One line per accepted ratio transfer.
  always @(posedge clk) begin
    if (!reset && ratio_val && ratio_rdy)
      $display("XFER ratio=%0d t=%0t", ratio, $time);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full period of ratio n: clk_en on the first cycle, ceil(n/2) cycles of clk_div high.
  task automatic expect_period(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      ratio_val = 1'b0;
      chk({tag, "_en"},  clk_en,  (i == 0) ? 1 : 0);
      chk({tag, "_div"}, clk_div, (i < (n + 1) / 2) ? 1 : 0);
    end
  endtask

  initial begin
    reset = 1'b1; ratio_val = 1'b0; ratio = 8'd0; run = 1'b0;
    tick();
    tick();
    chk("rst_en", clk_en, 0);
    chk("rst_div", clk_div, 0);
    chk("rst_rdy", ratio_rdy, 1);
`ifdef CLKDIV_STATUS_EN
    chk("rst_active", ratio_active, 2);
    chk("rst_upd", update_done, 0);
`endif

    // Default ratio 2 after reset.
    reset = 1'b0; run = 1'b1;
    expect_period(2, "t1a");
    expect_period(2, "t1b");
    expect_period(2, "t1c");

    // Load 5 while idle.
    run = 1'b0;
    tick();
    chk("t2_stop_en", clk_en, 0);
    chk("t2_stop_div", clk_div, 0);
    ratio_val = 1'b1; ratio = 8'd5; run = 1'b1;
    expect_period(5, "t2a");
    expect_period(5, "t2b");

    // Running at 4, offer 3 at cnt=1: shadowed until the wrap.
    run = 1'b0;
    tick();
    ratio_val = 1'b1; ratio = 8'd4; run = 1'b1;
    expect_period(4, "t3a");
    tick();
    chk("t3_c0_en", clk_en, 1);
    tick();
    chk("t3_c1_div", clk_div, 1);
    ratio_val = 1'b1; ratio = 8'd3;
    chk("t3_rdy_before", ratio_rdy, 1);
    tick();
    ratio_val = 1'b0;
    chk("t3_pend_rdy", ratio_rdy, 0);
    chk("t3_c2_en", clk_en, 0);
    chk("t3_c2_div", clk_div, 0);
    tick();
    chk("t3_c3_rdy", ratio_rdy, 0);
    chk("t3_c3_div", clk_div, 0);
    // Offered while pending: must not be taken.
    ratio_val = 1'b1; ratio = 8'd7;
    expect_period(3, "t3b");
    chk("t3_rdy_after", ratio_rdy, 1);
    expect_period(3, "t3c");

    // Clamping of 0 and 1, then the maximum ratio.
    run = 1'b0;
    tick();
    chk("t4_stop_en", clk_en, 0);
    ratio_val = 1'b1; ratio = 8'd0; run = 1'b1;
    expect_period(2, "t4_r0a");
    expect_period(2, "t4_r0b");
    run = 1'b0;
    tick();
    ratio_val = 1'b1; ratio = 8'd1; run = 1'b1;
    expect_period(2, "t4_r1a");
    expect_period(2, "t4_r1b");
    run = 1'b0;
    tick();
    ratio_val = 1'b1; ratio = 8'd255; run = 1'b1;
    expect_period(255, "t4_r255a");
    expect_period(255, "t4_r255b");

    // Transfer coincident with the wrap at ratio 4, then stop mid-period.
    run = 1'b0;
    tick();
    ratio_val = 1'b1; ratio = 8'd4; run = 1'b1;
    expect_period(4, "t5a");
    ratio_val = 1'b1; ratio = 8'd6;
    expect_period(4, "t5b");
    expect_period(6, "t5c");
    tick();
    chk("t5_c0_en", clk_en, 1);
    tick();
    chk("t5_c1_div", clk_div, 1);
    run = 1'b0;
    tick();
    chk("t5_stop_en", clk_en, 0);
    chk("t5_stop_div", clk_div, 0);
    chk("t5_stop_rdy", ratio_rdy, 1);

    // Reset while a ratio is pending discards it.
    ratio_val = 1'b1; ratio = 8'd5; run = 1'b1;
    tick();
    ratio_val = 1'b0;
    chk("t6_c0_en", clk_en, 1);
    tick();
    ratio_val = 1'b1; ratio = 8'd9;
    tick();
    chk("t6_pend_rdy", ratio_rdy, 0);
    reset = 1'b1;
    tick();
    chk("t6_rst_en", clk_en, 0);
    chk("t6_rst_div", clk_div, 0);
    chk("t6_rst_rdy", ratio_rdy, 1);
    ratio_val = 1'b0; run = 1'b0; reset = 1'b0;
    tick();
    chk("t6_rel_en", clk_en, 0);
    chk("t6_rel_div", clk_div, 0);
    chk("t6_rel_rdy", ratio_rdy, 1);
`ifdef CLKDIV_STATUS_EN
    chk("t6_active", ratio_active, 2);
    chk("t6_upd", update_done, 0);
`endif
    run = 1'b1;
    expect_period(2, "t6a");
    expect_period(2, "t6b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
